str_buffer_arbiter: RTL

- Round-robin arbiter and sequencer that shares one two-stage registered byte buffer among N_REQ requesters.
- Grants one requester at a time for a bounded burst and moves accepted beats through a buffer stage and an output stage.
- Tags each output beat with the source ID and applies downstream backpressure.
- Sits between multiple producers and a single consumer of the buffered stream.

---
 rtl/str_buffer_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/str_buffer_arbiter.sv
// Round-robin arbiter feeding a shared two-stage registered byte buffer.
// Optional macro STR_ARB_BEAT_COUNT_EN adds a saturating output handshake counter (beat_count).
module str_buffer_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    in_data,
    output logic [N_REQ-1:0]           in_ready,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    input  logic                       out_ready
`ifdef STR_ARB_BEAT_COUNT_EN
    ,
    output logic [15:0]                beat_count
`endif
);

    localparam int ID_W = $clog2(N_REQ);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [ID_W-1:0]   s1_id_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ID_W-1:0]   out_id_q;

    logic              stall;
    logic              accept;
    logic              win_valid;
    logic [ID_W-1:0]   win_idx;

    logic [DATA_W-1:0] in_slice [N_REQ];
    logic [ID_W-1:0]   scan_idx [N_REQ];
    logic [N_REQ-1:0]  scan_hit;

    // scan_idx[k] is the requester k+1 places after the last winner
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lanes
            assign in_slice[gi] = in_data[gi*DATA_W +: DATA_W];
            assign scan_idx[gi] = ID_W'((int'(last_q) + gi + 1) % N_REQ);
            assign scan_hit[gi] = req[scan_idx[gi]];
        end
    endgenerate

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = (state_q == ST_BUSY && !stall) ? grant_q : '0;
    assign accept   = |(req & in_ready);

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (scan_hit[k]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx[k];
            end
        end
    end

    // last_q doubles as the current owner index while BUSY
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        if (state_q == ST_IDLE) begin
            if (win_valid) begin
                state_d     = ST_BUSY;
                grant_d     = N_REQ'(1) << win_idx;
                last_d      = win_idx;
                burst_cnt_d = '0;
            end
        end else begin
            if (!req[last_q]) begin
                state_d = ST_IDLE;
                grant_d = '0;
            end else if (accept) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
                if (burst_cnt_q + 4'd1 == 4'(MAX_BURST)) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= ID_W'(N_REQ - 1);
            burst_cnt_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_id_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            if (!stall) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_data_q <= in_slice[last_q];
                    s1_id_q   <= last_q;
                end
                // Bubbles leave the previous data/id visible on the outputs
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= s1_data_q;
                    out_id_q   <= s1_id_q;
                end
            end
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q == ST_BUSY);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef STR_ARB_BEAT_COUNT_EN
    logic [15:0] beat_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
        end else if (out_valid_q && out_ready && beat_count_q != 16'hFFFF) begin
            beat_count_q <= beat_count_q + 16'd1;
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule
